// File: rtl/fmac_pkg.sv
// rtl/fmac_pkg.sv - shared constants and state type for the fmac unit and its sequencer
//   LANES / EXP_W / MAN_W / ACC_W : block-floating-point geometry
//   BLK_W                         : packed width of one 16-lane mantissa block
//   fmac_seq_state_t              : sequencer FSM states
package fmac_pkg;

    localparam int LANES = 16;
    localparam int EXP_W = 8;
    localparam int MAN_W = 4;
    localparam int ACC_W = 24;
    localparam int BLK_W = LANES * MAN_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } fmac_seq_state_t;

endpackage

// File: rtl/fmac_seq_if.sv
// rtl/fmac_seq_if.sv - bundle of job, operand stream, fmac and result signals of fmac_seq
//   job      : i_start, i_num_blk, o_busy
//   act/wgt  : i_*_valid, o_*_ready, i_*_E, i_*_M (lane i at [i*MAN_W+:MAN_W])
//   fmac     : o_mac_valid, o_mac_* operands, o_mac_prev_result_*, i_mac_result_*
//   result   : o_res_valid, i_res_ready, o_res_E, o_res_M
//   modports : slave = fmac_seq side, master = surrounding logic side
interface fmac_seq_if
    import fmac_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic             i_start;
    logic [CNT_W-1:0] i_num_blk;
    logic             o_busy;

    logic             i_act_valid;
    logic             o_act_ready;
    logic [EXP_W-1:0] i_act_E;
    logic [BLK_W-1:0] i_act_M;

    logic             i_wgt_valid;
    logic             o_wgt_ready;
    logic [EXP_W-1:0] i_wgt_E;
    logic [BLK_W-1:0] i_wgt_M;

    logic             o_mac_valid;
    logic [EXP_W-1:0] o_mac_Act_E;
    logic [BLK_W-1:0] o_mac_Act_M;
    logic [EXP_W-1:0] o_mac_Weight_E;
    logic [BLK_W-1:0] o_mac_Weight_M;
    logic [EXP_W-1:0] o_mac_prev_result_E;
    logic [ACC_W-1:0] o_mac_prev_result_M;
    logic [EXP_W-1:0] i_mac_result_E;
    logic [ACC_W-1:0] i_mac_result_M;

    logic             o_res_valid;
    logic             i_res_ready;
    logic [EXP_W-1:0] o_res_E;
    logic [ACC_W-1:0] o_res_M;

    modport slave (
        input  i_start, i_num_blk,
        output o_busy,
        input  i_act_valid, i_act_E, i_act_M,
        output o_act_ready,
        input  i_wgt_valid, i_wgt_E, i_wgt_M,
        output o_wgt_ready,
        output o_mac_valid, o_mac_Act_E, o_mac_Act_M, o_mac_Weight_E, o_mac_Weight_M,
        output o_mac_prev_result_E, o_mac_prev_result_M,
        input  i_mac_result_E, i_mac_result_M,
        output o_res_valid, o_res_E, o_res_M,
        input  i_res_ready
    );

    modport master (
        output i_start, i_num_blk,
        input  o_busy,
        output i_act_valid, i_act_E, i_act_M,
        input  o_act_ready,
        output i_wgt_valid, i_wgt_E, i_wgt_M,
        input  o_wgt_ready,
        input  o_mac_valid, o_mac_Act_E, o_mac_Act_M, o_mac_Weight_E, o_mac_Weight_M,
        input  o_mac_prev_result_E, o_mac_prev_result_M,
        output i_mac_result_E, i_mac_result_M,
        input  o_res_valid, o_res_E, o_res_M,
        output i_res_ready
    );

endinterface

// File: rtl/fmac_seq.sv
// rtl/fmac_seq.sv - job sequencer feeding one fmac block-floating-point MAC and accumulating its result
//   i_clk   : clock
//   i_reset : asynchronous active-high reset, discards any job in progress
//   bus     : fmac_seq_if.slave (job command, act/wgt block streams, fmac issue/result, final result)
//   FMAC_LAT: cycles from issue to valid fmac result (>=1); CNT_W: block-count width
module fmac_seq
    import fmac_pkg::*;
#(
    parameter int FMAC_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    fmac_seq_if.slave   bus
);

    localparam int LAT_W = (FMAC_LAT > 1) ? $clog2(FMAC_LAT) : 1;

    fmac_seq_state_t  state;
    fmac_seq_state_t  state_nxt;

    logic [CNT_W-1:0] rem;
    logic [LAT_W-1:0] lat_cnt;
    logic [EXP_W-1:0] acc_e;
    logic [ACC_W-1:0] acc_m;
    logic [EXP_W-1:0] act_e;
    logic [BLK_W-1:0] act_m;
    logic [EXP_W-1:0] wgt_e;
    logic [BLK_W-1:0] wgt_m;

    logic             start_ok;
    logic             load_hs;
    logic             capture;

    logic             busy_c;
    logic             rdy_c;
    logic             mac_valid_c;
    logic             res_valid_c;

    // Both streams are consumed together so activation and weight blocks never drift apart.
    assign start_ok = (state == ST_IDLE) && bus.i_start;
    assign load_hs  = (state == ST_LOAD) && bus.i_act_valid && bus.i_wgt_valid;
    assign capture  = (state == ST_WAIT) && (lat_cnt == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_nxt = (bus.i_num_blk == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_hs) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // rem==1 here means the block being captured is the last one.
                if (capture) begin
                    state_nxt = (rem == CNT_W'(1)) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                if (bus.i_res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_c      = 1'b1;
        rdy_c       = 1'b0;
        mac_valid_c = 1'b0;
        res_valid_c = 1'b0;
        case (state)
            ST_IDLE:  busy_c      = 1'b0;
            ST_LOAD:  rdy_c       = bus.i_act_valid && bus.i_wgt_valid;
            ST_ISSUE: mac_valid_c = 1'b1;
            ST_DONE:  res_valid_c = 1'b1;
            default:  busy_c      = 1'b1;
        endcase
    end

    // Issue registers, accumulator and counters. Operands stay put from ISSUE
    // until the result is captured because they only reload on the next LOAD handshake.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rem     <= '0;
            lat_cnt <= '0;
            acc_e   <= '0;
            acc_m   <= '0;
            act_e   <= '0;
            act_m   <= '0;
            wgt_e   <= '0;
            wgt_m   <= '0;
        end else begin
            if (start_ok) begin
                rem   <= bus.i_num_blk;
                acc_e <= '0;
                acc_m <= '0;
            end

            if (load_hs) begin
                act_e <= bus.i_act_E;
                act_m <= bus.i_act_M;
                wgt_e <= bus.i_wgt_E;
                wgt_m <= bus.i_wgt_M;
            end

            if (state == ST_ISSUE) begin
                lat_cnt <= LAT_W'(FMAC_LAT - 1);
            end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (capture) begin
                acc_e <= bus.i_mac_result_E;
                acc_m <= bus.i_mac_result_M;
                rem   <= rem - CNT_W'(1);
            end
        end
    end

    assign bus.o_busy              = busy_c;
    assign bus.o_act_ready         = rdy_c;
    assign bus.o_wgt_ready         = rdy_c;
    assign bus.o_mac_valid         = mac_valid_c;
    assign bus.o_mac_Act_E         = act_e;
    assign bus.o_mac_Act_M         = act_m;
    assign bus.o_mac_Weight_E      = wgt_e;
    assign bus.o_mac_Weight_M      = wgt_m;
    assign bus.o_mac_prev_result_E = acc_e;
    assign bus.o_mac_prev_result_M = acc_m;
    assign bus.o_res_valid         = res_valid_c;
    assign bus.o_res_E             = acc_e;
    assign bus.o_res_M             = acc_m;

endmodule
